// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bus between an initiator and mem_responder.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. The side driving valid holds it and its payload steady until that
// edge. The side driving ready may raise or lower ready at any time. For
// requests, valid is req_valid and ready is req_ready. For responses, valid is
// rsp_valid and ready is rsp_ready.
//
// Signals:
//   req_valid, req_addr, req_wren, req_wr_data, req_be  initiator -> responder
//   req_ready                                            responder -> initiator
//   rsp_valid, rsp_rd_data, rsp_err                      responder -> initiator
//   rsp_ready                                            initiator -> responder
// Modports: master = initiator side, slave = responder side.
interface mem_responder_if #(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_addr;
  logic               req_wren;
  logic [WIDTH-1:0]   req_wr_data;
  logic [WIDTH/8-1:0] req_be;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rd_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_addr, req_wren, req_wr_data, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wren, req_wr_data, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rd_data, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- word-addressed memory behind a valid/ready request/response
// bus. Each request gets exactly one response, LATENCY cycles after the request
// is accepted. Only one request can be in flight at a time.
//
// Ports:
//   clk        single clock; all state updates on its rising edge
//   rst        asynchronous, active-low reset
//   bus        mem_responder_if.slave (req_* in, rsp_* out)
//   state_dbg  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// Build option:
//   MEM_RESPONDER_ADDR_CHECK_EN
//     Defined: any set address bit above DEPTH_LOG2+1 makes the request out of
//     range. The memory is not accessed, and the response returns
//     rsp_err=1 with rsp_rd_data=0.
//     Undefined: the upper address bits are ignored, so addresses wrap, and
//     rsp_err is always 0.
module mem_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  output logic [1:0]     state_dbg
);

  localparam int             BYTES    = WIDTH / 8;
  localparam int             DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]     CNT_LOAD = 4'(LATENCY - 1);
  localparam logic           LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]            cnt;
  logic                  ready_en;
  logic                  accept;
  logic                  enter_resp;

  // Request fields captured at the accept edge.
  logic [DEPTH_LOG2-1:0] hold_idx;
  logic                  hold_wren;
  logic [WIDTH-1:0]      hold_wr_data;
  logic [BYTES-1:0]      hold_be;
  logic                  hold_oor;

  // Operand of the access performed on the edge that enters RESP.
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_oor;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic                  op_wren;
  logic [WIDTH-1:0]      op_wr_data;
  logic [BYTES-1:0]      op_be;
  logic                  op_oor;

  logic [WIDTH-1:0]      rsp_rd_data_q;
  logic                  rsp_err_q;

  logic [WIDTH-1:0]      mem [0:DEPTH-1];

  assign req_idx = bus.req_addr[DEPTH_LOG2+1:2];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  assign req_oor = |(bus.req_addr >> (DEPTH_LOG2 + 2));
`else
  assign req_oor = 1'b0;
`endif

  assign accept = bus.req_valid && bus.req_ready;

  // When LATENCY is 1, RESP is entered on the accept edge itself, before the
  // holding registers are loaded. The live request must then feed the access.
  always_comb begin
    if (state == S_IDLE) begin
      op_idx     = req_idx;
      op_wren    = bus.req_wren;
      op_wr_data = bus.req_wr_data;
      op_be      = bus.req_be;
      op_oor     = req_oor;
    end else begin
      op_idx     = hold_idx;
      op_wren    = hold_wren;
      op_wr_data = hold_wr_data;
      op_be      = hold_be;
      op_oor     = hold_oor;
    end
  end

  // The counter holds the number of WAIT edges still to go. The edge that
  // takes it from 1 to 0 is the edge that enters RESP.
  // The rst term keeps a request that is pending when reset asserts from
  // reaching memory.
  assign enter_resp = rst &&
                      (((state == S_IDLE) && accept && LAT_ONE) ||
                       ((state == S_WAIT) && (cnt == 4'd1)));

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = LAT_ONE ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. ready_en keeps req_ready low until the first edge after
  // reset is released.
  always_comb begin
    bus.req_ready = (state == S_IDLE) && ready_en;
    bus.rsp_valid = (state == S_RESP);
    state_dbg     = state;
  end

  // Datapath and response registers. The response fields only change on the
  // edge that enters RESP, so they stay stable while RESP is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en      <= 1'b0;
      cnt           <= '0;
      hold_idx      <= '0;
      hold_wren     <= 1'b0;
      hold_wr_data  <= '0;
      hold_be       <= '0;
      hold_oor      <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if ((state == S_IDLE) && accept) begin
        hold_idx     <= req_idx;
        hold_wren    <= bus.req_wren;
        hold_wr_data <= bus.req_wr_data;
        hold_be      <= bus.req_be;
        hold_oor     <= req_oor;
        cnt          <= CNT_LOAD;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err_q     <= op_oor;
        rsp_rd_data_q <= (op_wren || op_oor) ? '0 : mem[op_idx];
      end
    end
  end

  // The memory array has no reset. On this edge the response register
  // samples the word before the write lands.
  always_ff @(posedge clk) begin
    if (enter_resp && op_wren && !op_oor) begin
      for (int b = 0; b < BYTES; b++) begin
        if (op_be[b]) mem[op_idx][b*8 +: 8] <= op_wr_data[b*8 +: 8];
      end
    end
  end

  // rsp_err_q is always 0 when the address check is compiled out.
  assign bus.rsp_rd_data = rsp_rd_data_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data and address width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of WIDTH-bit words stored.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response valid (legal range 1..15).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning the reset; asynchronous and active-low.
REQ-006 SHALL have port req_valid  input  1  meaning the initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  meaning the responder can accept a request this cycle.
REQ-008 SHALL have port req_addr  input  WIDTH  meaning the byte address.
REQ-009 SHALL have port req_wren  input  1  meaning 1 = write, 0 = read.
REQ-010 SHALL have port req_wr_data  input  WIDTH  meaning the write data.
REQ-011 SHALL have port req_be  input  WIDTH/8  meaning the byte enables for writes.
REQ-012 SHALL have port rsp_valid  output  1  meaning a response is presented.
REQ-013 SHALL have port rsp_ready  input  1  meaning the initiator accepts the response.
REQ-014 SHALL have port rsp_rd_data  output  WIDTH  meaning the read data.
REQ-015 SHALL have port rsp_err  output  1  meaning the request was out of range.

Function
REQ-016 SHALL implement a three-state FSM:
- IDLE: req_ready=1.
- WAIT: latency counting.
- RESP: rsp_valid=1.
REQ-017 SHALL treat a request as accepted on a rising edge where req_valid && req_ready, and capture addr, wren, wr_data and be into holding registers at that edge.
REQ-018 SHALL transition IDLE->RESP when LATENCY=1, else IDLE->WAIT, loading a down-counter with LATENCY-1.
REQ-019 SHALL transition WAIT->RESP on the edge where the counter reaches 0, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 SHALL transition RESP->IDLE on the edge where rsp_valid && rsp_ready, and hold RESP with all rsp_* outputs stable while rsp_ready=0.
REQ-021 SHALL deassert req_ready in WAIT and RESP, so back-to-back requests are accepted at most once every LATENCY+1 cycles.
REQ-022 SHALL index memory with req_addr[DEPTH_LOG2+1:2] and ignore req_addr[1:0].
REQ-023 SHALL perform the memory read or write on the edge entering RESP, updating only the bytes whose req_be bit is 1.
REQ-024 SHALL drive rsp_rd_data with the pre-write word for reads and with 0 for writes.
REQ-025 SHALL make a write followed by a read of the same address return the written bytes merged with the old unenabled bytes.
REQ-026 SHALL ignore req_* inputs outside the IDLE accept cycle, and SHALL NOT accept a request when req_valid and a response are pending simultaneously.

Reset
REQ-027 SHALL, on rst=0 at any time including mid-WAIT or mid-RESP, immediately force IDLE, counter=0, rsp_valid=0, rsp_rd_data=0 and rsp_err=0.
REQ-028 SHALL drive req_ready=1 one cycle after rst deasserts.
REQ-029 SHALL NOT reset memory contents; a request abandoned in WAIT when reset asserts SHALL NOT modify memory.

Configuration
REQ-030 SHALL compile out-of-range checking in or out with the macro MEM_RESPONDER_ADDR_CHECK_EN.
REQ-031 SHALL, with MEM_RESPONDER_ADDR_CHECK_EN defined, treat a request with any nonzero req_addr bit above DEPTH_LOG2+1 as out of range: no memory access, rsp_err=1 and rsp_rd_data=0 with normal latency.
REQ-032 SHALL, without MEM_RESPONDER_ADDR_CHECK_EN, ignore upper address bits (addresses alias/wrap) and tie rsp_err to 0.

Verification
REQ-033 SHALL cover: reset, then write addr 0x10, data 0xDEADBEEF, be 0xF, then read 0x10 -> rsp_rd_data=0xDEADBEEF, rsp_valid exactly 2 cycles after each accept.
REQ-034 SHALL cover: write 0x11223344 to 0x20, then write 0xAABBCCDD with be 0x5, then read 0x20 -> 0x11BB33DD.
REQ-035 SHALL cover: read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rd_data stable, req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-036 SHALL cover: rst pulsed low mid-WAIT on a write of 0xCAFEF00D to 0x30 -> rsp_valid=0 immediately; a later read of 0x30 returns the prior contents.
REQ-037 SHALL cover: read of 0x00001000 with DEPTH_LOG2=10 -> with macro, rsp_err=1 and data 0; without macro, data equal to address 0x0.
REQ-038 SHALL cover: LATENCY=1 build with continuous req_valid -> rsp_valid one cycle after accept and accepts spaced 2 cycles apart.
